// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmit path: FSM states, frame bit
// positions and the microsecond-to-cycle conversion used to size timers.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SHIFT,
        RELEASE,
        FINISH
    } state_t;

    localparam int PAR_IDX  = 8;
    localparam int STOP_IDX = 9;
    localparam int ACK_IDX  = 10;
    localparam int FILT_LEN = 8;

    function automatic int us_to_cycles(input int clk_freq, input int us);
        return (clk_freq / 1000000) * us;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// PS/2 pad conditioning: 2-FF synchronisers, falling-edge detect on the clock
// line, and an optional 8-sample clock stability filter (PS2_TX_FILTER_EN).
module ps2_line_sync
    import ps2_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_clk_pad,
    input  logic i_data_pad,
    output logic o_clk_level,
    output logic o_data_level,
    output logic o_fall
);

    logic [1:0] r_clk_sync;
    logic [1:0] r_data_sync;
    logic       r_level_d;
    logic       r_fall;
    logic       w_level;

    // Idle PS/2 lines float high, so synchronisers come out of reset at 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], i_clk_pad};
            r_data_sync <= {r_data_sync[0], i_data_pad};
        end
    end

`ifdef PS2_TX_FILTER_EN
    localparam int FCNT_W = $clog2(FILT_LEN);

    logic              r_filt;
    logic [FCNT_W-1:0] r_fcnt;

    // The filtered level flips only after FILT_LEN consecutive disagreeing samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_filt <= 1'b1;
            r_fcnt <= '0;
        end else if (r_clk_sync[1] == r_filt) begin
            r_fcnt <= '0;
        end else if (r_fcnt == FCNT_W'(FILT_LEN - 1)) begin
            r_filt <= r_clk_sync[1];
            r_fcnt <= '0;
        end else begin
            r_fcnt <= r_fcnt + 1'b1;
        end
    end

    assign w_level = r_filt;
`else
    assign w_level = r_clk_sync[1];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_level_d <= 1'b1;
            r_fall    <= 1'b0;
        end else begin
            r_level_d <= w_level;
            r_fall    <= r_level_d & ~w_level;
        end
    end

    assign o_clk_level  = w_level;
    assign o_data_level = r_data_sync[1];
    assign o_fall       = r_fall;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (inhibit, request-to-send, 11-bit
// frame, ACK check). Define PS2_TX_FILTER_EN to enable the clock glitch filter.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_FREQ         = 50000000,
    parameter int INHIBIT_US       = 100,
    parameter int START_TIMEOUT_US = 15000,
    parameter int FRAME_TIMEOUT_US = 2000
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int INH     = us_to_cycles(CLK_FREQ, INHIBIT_US);
    localparam int TST     = us_to_cycles(CLK_FREQ, START_TIMEOUT_US);
    localparam int TFR     = us_to_cycles(CLK_FREQ, FRAME_TIMEOUT_US);
    localparam int CNT_MAX = (INH > TST) ? ((INH > TFR) ? INH : TFR)
                                         : ((TST > TFR) ? TST : TFR);
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [3:0] N_PAR  = 4'(PAR_IDX);
    localparam logic [3:0] N_STOP = 4'(STOP_IDX);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_n;
    logic [7:0]       r_sr;
    logic             r_par;
    logic             r_err;
    logic             w_fail;
    logic             w_accept;
    logic             w_reload;
    logic             w_clk_lvl;
    logic             w_data_lvl;
    logic             w_fall;

    ps2_line_sync u_sync (
        .clk          (clk),
        .reset        (reset),
        .i_clk_pad    (ps2_clk_i),
        .i_data_pad   (ps2_data_i),
        .o_clk_level  (w_clk_lvl),
        .o_data_level (w_data_lvl),
        .o_fall       (w_fall)
    );

    assign w_accept = tx_valid & tx_ready;

    // The frame timer keeps running from SHIFT into RELEASE; every other entry restarts it.
    assign w_reload = (w_state_next != r_state) &&
                      !(r_state == SHIFT && w_state_next == RELEASE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_n     <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_reload ? '0 : r_cnt + 1'b1;
            if (r_state == RTS && w_fall)
                r_n <= '0;
            else if (r_state == SHIFT && w_fall && r_n != N_STOP)
                r_n <= r_n + 1'b1;
            if (w_state_next == FINISH && r_state != FINISH)
                r_err <= w_fail;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_sr  <= tx_data;
            r_par <= ~^tx_data;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_fail       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_accept)
                    w_state_next = INHIBIT;
            end
            INHIBIT: begin
                if (r_cnt == CNT_W'(INH - 1))
                    w_state_next = RTS;
            end
            RTS: begin
                if (w_fall) begin
                    w_state_next = SHIFT;
                end else if (r_cnt == CNT_W'(TST - 1)) begin
                    w_state_next = FINISH;
                    w_fail       = 1'b1;
                end
            end
            // The fall after the stop bit is where the device's ACK is sampled.
            SHIFT: begin
                if (w_fall && r_n == N_STOP) begin
                    w_state_next = w_data_lvl ? FINISH : RELEASE;
                    w_fail       = w_data_lvl;
                end else if (r_cnt == CNT_W'(TFR - 1)) begin
                    w_state_next = FINISH;
                    w_fail       = 1'b1;
                end
            end
            RELEASE: begin
                if (w_clk_lvl && w_data_lvl) begin
                    w_state_next = FINISH;
                end else if (r_cnt == CNT_W'(TFR - 1)) begin
                    w_state_next = FINISH;
                    w_fail       = 1'b1;
                end
            end
            FINISH: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        tx_ready    = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        err         = 1'b0;
        unique case (r_state)
            IDLE: begin
                tx_ready = 1'b1;
                busy     = 1'b0;
            end
            INHIBIT: begin
                ps2_clk_oe = 1'b1;
            end
            RTS: begin
                ps2_data_oe = 1'b1;
            end
            SHIFT: begin
                if (r_n < N_PAR)
                    ps2_data_oe = ~r_sr[r_n[2:0]];
                else if (r_n == N_PAR)
                    ps2_data_oe = ~r_par;
            end
            FINISH: begin
                done = 1'b1;
                err  = r_err;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a 12.5 kHz device model at CLK_FREQ=1 MHz.
module tb_ps2_host_tx;

    localparam int INH = 100;
    localparam int TST = 15000;
    localparam int TFR = 2000;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ps2_clk_i;
    logic       ps2_data_i;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       done;
    logic       err;

    logic dev_clk_low  = 1'b0;
    logic dev_data_low = 1'b0;

    int checks   = 0;
    int failures = 0;

    int   cyc = 0;
    logic prev_clk_oe  = 1'b0;
    logic prev_data_oe = 1'b0;
    int   t_clk_rise   = 0;
    int   t_clk_fall   = 0;
    int   t_data_fall  = 0;
    int   t_done       = 0;
    int   done_cnt     = 0;
    logic done_err     = 1'b0;
    logic done_clk_oe  = 1'b0;
    logic done_data_oe = 1'b0;

    assign ps2_clk_i  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_i = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .CLK_FREQ         (1000000),
        .INHIBIT_US       (100),
        .START_TIMEOUT_US (15000),
        .FRAME_TIMEOUT_US (2000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .ps2_clk_i   (ps2_clk_i),
        .ps2_data_i  (ps2_data_i),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        prev_clk_oe  <= ps2_clk_oe;
        prev_data_oe <= ps2_data_oe;
        if (ps2_clk_oe && !prev_clk_oe)  t_clk_rise  <= cyc;
        if (!ps2_clk_oe && prev_clk_oe)  t_clk_fall  <= cyc;
        if (!ps2_data_oe && prev_data_oe) t_data_fall <= cyc;
        if (done) begin
            done_cnt     <= done_cnt + 1;
            done_err     <= err;
            done_clk_oe  <= ps2_clk_oe;
            done_data_oe <= ps2_data_oe;
            t_done       <= cyc;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
    endtask

    task automatic wait_rts(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (busy && !ps2_clk_oe && ps2_data_oe) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    task automatic wait_done(input int start, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done_cnt != start) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    // Device clocks 40 low / 40 high; samples data on each rising edge.
    task automatic dev_clock(input int pulses, input bit ack, output logic [9:0] bits);
        bits = '0;
        for (int i = 0; i < pulses; i++) begin
            dev_clk_low = 1'b1;
            tick(40);
            dev_clk_low = 1'b0;
            if (i < 10) bits[i] = ps2_data_i;
            if (i == 9 && ack) dev_data_low = 1'b1;
            if (i == 10) dev_data_low = 1'b0;
            tick(40);
        end
    endtask

    initial begin
        logic [9:0] bits;
        bit         ok;
        int         n0;

        reset    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        tick(3);
        check("rst_clk_oe",   32'(ps2_clk_oe),  32'd0);
        check("rst_data_oe",  32'(ps2_data_oe), 32'd0);
        check("rst_busy",     32'(busy),        32'd0);
        check("rst_done",     32'(done),        32'd0);
        check("rst_err",      32'(err),         32'd0);
        check("rst_tx_ready", 32'(tx_ready),    32'd1);
        reset = 1'b0;
        tick(3);

        // 0xED with ACK
        n0 = done_cnt;
        send(8'hED);
        wait_rts(ok);
        check("ed_rts_reached", 32'(ok), 32'd1);
        tick(40);
        dev_clock(11, 1'b1, bits);
        wait_done(n0, 400, ok);
        check("ed_done_seen",  32'(ok), 32'd1);
        check("ed_inhibit_len", 32'(t_clk_fall - t_clk_rise), 32'(INH));
        check("ed_data_bits",  32'(bits[7:0]), 32'h0000_00ED);
        check("ed_parity",     32'(bits[8]),   32'd1);
        check("ed_stop",       32'(bits[9]),   32'd1);
        check("ed_err",        32'(done_err),  32'd0);
        tick(2);
        check("ed_ready_after", 32'(tx_ready), 32'd1);

        // 0xF4 with NACK
        n0 = done_cnt;
        send(8'hF4);
        wait_rts(ok);
        check("f4_rts_reached", 32'(ok), 32'd1);
        tick(40);
        dev_clock(11, 1'b0, bits);
        wait_done(n0, 400, ok);
        check("f4_done_seen", 32'(ok), 32'd1);
        check("f4_data_bits", 32'(bits[7:0]), 32'h0000_00F4);
        check("f4_parity",    32'(bits[8]),   32'd0);
        check("f4_err",       32'(done_err),  32'd1);
        check("f4_clk_oe",    32'(done_clk_oe),  32'd0);
        check("f4_data_oe",   32'(done_data_oe), 32'd0);
        tick(2);

        // Device never clocks: start timeout
        n0 = done_cnt;
        send(8'hA5);
        wait_rts(ok);
        check("st_rts_reached", 32'(ok), 32'd1);
        wait_done(n0, TST + 200, ok);
        check("st_done_seen", 32'(ok), 32'd1);
        check("st_err",       32'(done_err), 32'd1);
        check("st_latency",   32'(t_done - t_clk_fall), 32'(TST));
        tick(2);

        // Device stops after 5 bits: frame timeout
        n0 = done_cnt;
        send(8'hFF);
        wait_rts(ok);
        check("ft_rts_reached", 32'(ok), 32'd1);
        tick(40);
        dev_clock(5, 1'b0, bits);
        wait_done(n0, TFR + 200, ok);
        check("ft_done_seen", 32'(ok), 32'd1);
        check("ft_err",       32'(done_err), 32'd1);
        check("ft_latency",   32'(t_done - t_data_fall), 32'(TFR));
        check("ft_clk_oe",    32'(done_clk_oe),  32'd0);
        check("ft_data_oe",   32'(done_data_oe), 32'd0);
        tick(2);

        // Reset during SHIFT at bit 4, then a clean 0x55
        send(8'h00);
        wait_rts(ok);
        check("rs_rts_reached", 32'(ok), 32'd1);
        tick(40);
        dev_clock(5, 1'b0, bits);
        check("rs_busy_before",    32'(busy),        32'd1);
        check("rs_data_oe_before", 32'(ps2_data_oe), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rs_clk_oe_async",  32'(ps2_clk_oe),  32'd0);
        check("rs_data_oe_async", 32'(ps2_data_oe), 32'd0);
        tick(2);
        reset = 1'b0;
        tick(1);
        check("rs_tx_ready", 32'(tx_ready), 32'd1);
        check("rs_busy",     32'(busy),     32'd0);

        n0 = done_cnt;
        send(8'h55);
        wait_rts(ok);
        check("x55_rts_reached", 32'(ok), 32'd1);
        tick(40);
        dev_clock(11, 1'b1, bits);
        wait_done(n0, 400, ok);
        check("x55_done_seen", 32'(ok), 32'd1);
        check("x55_data_bits", 32'(bits[7:0]), 32'h0000_0055);
        check("x55_parity",    32'(bits[8]),   32'd1);
        check("x55_err",       32'(done_err),  32'd0);
        tick(2);

        // 3-cycle clock glitch during RTS
        send(8'hFF);
        wait_rts(ok);
        check("gl_rts_reached", 32'(ok), 32'd1);
        tick(20);
        dev_clk_low = 1'b1;
        tick(3);
        dev_clk_low = 1'b0;
        tick(20);
`ifdef PS2_TX_FILTER_EN
        check("gl_data_oe", 32'(ps2_data_oe), 32'd1);
`else
        check("gl_data_oe", 32'(ps2_data_oe), 32'd0);
`endif
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(2);
        check("gl_tx_ready", 32'(tx_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
